// File: rtl/dlf16_result_wb_if.sv
// -----------------------------------------------------------------------------
// dlf16_result_wb_if
// Result and writeback handshake bundle for dlf16_result_wb.
//   res_*  : upstream FPU result channel (valid/ready, data, exception flags, tag)
//   wb_*   : register-file writeback channel (valid/ready, data, tag, flags)
// Modports:
//   master : environment side (drives results, accepts writebacks)
//   slave  : writeback stage side
// -----------------------------------------------------------------------------
interface dlf16_result_wb_if #(
    parameter int TAG_W = 5
);
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic [4:0]       res_exc;
    logic [TAG_W-1:0] res_tag;

    logic             wb_valid;
    logic             wb_ready;
    logic [15:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [4:0]       wb_exc;

    modport master (
        output res_valid, res_data, res_exc, res_tag, wb_ready,
        input  res_ready, wb_valid, wb_data, wb_tag, wb_exc
    );

    modport slave (
        input  res_valid, res_data, res_exc, res_tag, wb_ready,
        output res_ready, wb_valid, wb_data, wb_tag, wb_exc
    );
endinterface

// File: rtl/dlf16_result_wb.sv
// -----------------------------------------------------------------------------
// dlf16_result_wb
// Writeback stage for DLFloat16 FPU results. Buffers results and their 5-bit
// exception flags {NV,DZ,OF,UF,NX} in a small in-order FIFO, optionally
// rewrites NaN results to the canonical 16'h7FFF, and accumulates sticky
// exception flags as entries are written back.
// Ports:
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   bus         : result/writeback handshake (slave modport)
//   i_flags_clr : one-cycle pulse clearing the sticky flags
//   o_fflags    : sticky accumulated exception flags
//   o_count     : current FIFO occupancy
// -----------------------------------------------------------------------------
module dlf16_result_wb #(
    parameter int  DEPTH     = 2,
    parameter int  TAG_W     = 5,
    parameter bit  CANON_NAN = 1'b1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dlf16_result_wb_if.slave        bus,
    input  logic                    i_flags_clr,
    output logic [4:0]              o_fflags,
    output logic [CNT_W-1:0]        o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic [4:0]       exc;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_fflags;

    logic   w_res_ready;
    logic   w_wb_valid;
    logic   w_push;
    logic   w_pop;
    entry_t w_head;
    entry_t w_in;

    // Both handshake outputs depend only on registered occupancy, so a full
    // FIFO refuses a push even in a cycle where it is also popping.
    assign w_res_ready = (r_count != CNT_W'(DEPTH));
    assign w_wb_valid  = (r_count != '0);
    assign w_push      = bus.res_valid && w_res_ready;
    assign w_pop       = w_wb_valid && bus.wb_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Any NaN (all-ones exponent and mantissa) collapses to positive canonical NaN.
    always_comb begin
        w_in.tag = bus.res_tag;
        w_in.exc = bus.res_exc;
        if (CANON_NAN && (bus.res_data[14:0] == 15'h7FFF)) begin
            w_in.data = 16'h7FFF;
        end else begin
            w_in.data = bus.res_data;
        end
    end

    // NOTE: storage is reset along with the pointers so the writeback outputs
    // read as zero after reset instead of X; all sequential state uses <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fflags <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            // A clear never masks the flags of the entry popped in the same cycle.
            r_fflags <= (i_flags_clr ? 5'b0 : r_fflags) | (w_pop ? w_head.exc : 5'b0);
        end
    end

    assign bus.res_ready = w_res_ready;
    assign bus.wb_valid  = w_wb_valid;
    assign bus.wb_data   = w_head.data;
    assign bus.wb_tag    = w_head.tag;
    assign bus.wb_exc    = w_head.exc;
    assign o_fflags      = r_fflags;
    assign o_count       = r_count;
endmodule

// File: tb/tb_dlf16_result_wb.sv
// -----------------------------------------------------------------------------
// tb_dlf16_result_wb
// Directed bench for dlf16_result_wb (DEPTH=2, TAG_W=5). A second instance
// with CANON_NAN=0 shows that NaN results pass through untouched when
// canonicalization is disabled.
// -----------------------------------------------------------------------------
module tb_dlf16_result_wb;
    logic       clk;
    logic       rst_n;
    logic       flags_clr;
    logic [4:0] fflags;
    logic [1:0] count;
    logic [4:0] fflags0;
    logic [1:0] count0;

    int n_pass  = 0;
    int n_total = 0;

    dlf16_result_wb_if #(.TAG_W(5)) bus  ();
    dlf16_result_wb_if #(.TAG_W(5)) bus0 ();

    dlf16_result_wb #(.DEPTH(2), .TAG_W(5), .CANON_NAN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_flags_clr (flags_clr),
        .o_fflags    (fflags),
        .o_count     (count)
    );

    dlf16_result_wb #(.DEPTH(2), .TAG_W(5), .CANON_NAN(1'b0)) dut_raw (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus0),
        .i_flags_clr (flags_clr),
        .o_fflags    (fflags0),
        .o_count     (count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] e, input logic [4:0] t);
        bus.res_valid = v;
        bus.res_data  = d;
        bus.res_exc   = e;
        bus.res_tag   = t;
    endtask

    task automatic clear_flags();
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        bus.wb_ready   = 1'b1;
        bus0.res_valid = 1'b0;
        bus0.res_data  = 16'h0;
        bus0.res_exc   = 5'h0;
        bus0.res_tag   = 5'h0;
        bus0.wb_ready  = 1'b1;
        flags_clr      = 1'b0;
        step();
        step();
        n_total++;
        if ({bus.wb_valid, bus.res_ready, count, fflags} !== {1'b0, 1'b1, 2'd0, 5'd0})
            $display("FAIL reset_ctrl: got v=%b rdy=%b cnt=%0d ff=%b, want v=0 rdy=1 cnt=0 ff=00000",
                     bus.wb_valid, bus.res_ready, count, fflags);
        else n_pass++;
        n_total++;
        if ({bus.wb_data, bus.wb_tag, bus.wb_exc} !== 26'd0)
            $display("FAIL reset_data: got data=%h tag=%0d exc=%b, want all zero",
                     bus.wb_data, bus.wb_tag, bus.wb_exc);
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive(1'b1, 16'h3E00, 5'b00001, 5'd3);
        bus.wb_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        n_total++;
        if ({bus.wb_valid, bus.wb_data, bus.wb_tag, bus.wb_exc, count} !== {1'b1, 16'h3E00, 5'd3, 5'b00001, 2'd1})
            $display("FAIL single_out: got v=%b data=%h tag=%0d exc=%b cnt=%0d, want v=1 data=3e00 tag=3 exc=00001 cnt=1",
                     bus.wb_valid, bus.wb_data, bus.wb_tag, bus.wb_exc, count);
        else n_pass++;
        step();
        n_total++;
        if ({bus.wb_valid, count, fflags} !== {1'b0, 2'd0, 5'b00001})
            $display("FAIL single_pop: got v=%b cnt=%0d ff=%b, want v=0 cnt=0 ff=00001",
                     bus.wb_valid, count, fflags);
        else n_pass++;
        clear_flags();
        n_total++;
        if (fflags !== 5'b00000)
            $display("FAIL flags_clear: got %b, want 00000", fflags);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        drive(1'b1, 16'h1111, 5'h0, 5'd1);
        step();
        n_total++;
        if ({bus.res_ready, count} !== {1'b1, 2'd1})
            $display("FAIL bp_first: got rdy=%b cnt=%0d, want rdy=1 cnt=1", bus.res_ready, count);
        else n_pass++;
        drive(1'b1, 16'h2222, 5'h0, 5'd2);
        step();
        n_total++;
        if ({bus.res_ready, count} !== {1'b0, 2'd2})
            $display("FAIL bp_full: got rdy=%b cnt=%0d, want rdy=0 cnt=2", bus.res_ready, count);
        else n_pass++;
        // Third result presented while full; a stray value meanwhile must be ignored.
        drive(1'b1, 16'h4444, 5'h0, 5'd4);
        step();
        drive(1'b1, 16'h3333, 5'h0, 5'd3);
        step();
        n_total++;
        if ({bus.res_ready, count, bus.wb_data, bus.wb_tag} !== {1'b0, 2'd2, 16'h1111, 5'd1})
            $display("FAIL bp_held: got rdy=%b cnt=%0d data=%h tag=%0d, want rdy=0 cnt=2 data=1111 tag=1",
                     bus.res_ready, count, bus.wb_data, bus.wb_tag);
        else n_pass++;
        // Full with push and pop offered: only the pop happens.
        bus.wb_ready = 1'b1;
        step();
        n_total++;
        if ({bus.res_ready, count, bus.wb_data, bus.wb_tag} !== {1'b1, 2'd1, 16'h2222, 5'd2})
            $display("FAIL full_pushpop: got rdy=%b cnt=%0d data=%h tag=%0d, want rdy=1 cnt=1 data=2222 tag=2",
                     bus.res_ready, count, bus.wb_data, bus.wb_tag);
        else n_pass++;
        step();
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        n_total++;
        if ({count, bus.wb_data, bus.wb_tag} !== {2'd1, 16'h3333, 5'd3})
            $display("FAIL bp_third: got cnt=%0d data=%h tag=%0d, want cnt=1 data=3333 tag=3",
                     count, bus.wb_data, bus.wb_tag);
        else n_pass++;
        step();
        n_total++;
        if ({bus.wb_valid, count} !== {1'b0, 2'd0})
            $display("FAIL bp_drain: got v=%b cnt=%0d, want v=0 cnt=0", bus.wb_valid, count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        bus.wb_ready = 1'b1;
        // First push into an empty FIFO while wb_ready is high: no bypass, count 0->1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 5'h0, 5'(i + 8));
            step();
            n_total++;
            if ({bus.wb_valid, count, bus.wb_data, bus.wb_tag} !== {1'b1, 2'd1, vals[i], 5'(i + 8)})
                $display("FAIL b2b_%0d: got v=%b cnt=%0d data=%h tag=%0d, want v=1 cnt=1 data=%h tag=%0d",
                         i, bus.wb_valid, count, bus.wb_data, bus.wb_tag, vals[i], i + 8);
            else n_pass++;
        end
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        step();
        n_total++;
        if ({bus.wb_valid, count, fflags} !== {1'b0, 2'd0, 5'd0})
            $display("FAIL b2b_drain: got v=%b cnt=%0d ff=%b, want v=0 cnt=0 ff=00000",
                     bus.wb_valid, count, fflags);
        else n_pass++;
    endtask

    task automatic test_nan();
        bus.wb_ready  = 1'b0;
        bus0.wb_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 5'b10000, 5'd7);
        bus0.res_valid = 1'b1;
        bus0.res_data  = 16'hFFFF;
        bus0.res_exc   = 5'b10000;
        bus0.res_tag   = 5'd7;
        step();
        drive(1'b1, 16'hFFFE, 5'b00000, 5'd6);
        bus0.res_valid = 1'b0;
        step();
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        n_total++;
        if ({bus.wb_data, bus.wb_exc} !== {16'h7FFF, 5'b10000})
            $display("FAIL nan_canon: got data=%h exc=%b, want data=7fff exc=10000", bus.wb_data, bus.wb_exc);
        else n_pass++;
        n_total++;
        if (bus0.wb_data !== 16'hFFFF)
            $display("FAIL nan_raw: got %h, want ffff", bus0.wb_data);
        else n_pass++;
        bus.wb_ready  = 1'b1;
        bus0.wb_ready = 1'b1;
        step();
        n_total++;
        if ({fflags, bus.wb_data} !== {5'b10000, 16'hFFFE})
            $display("FAIL nan_pop: got ff=%b data=%h, want ff=10000 data=fffe", fflags, bus.wb_data);
        else n_pass++;
        step();
        clear_flags();
    endtask

    task automatic test_flag_clr_race();
        bus.wb_ready = 1'b1;
        drive(1'b1, 16'h1234, 5'b00100, 5'd1);
        step();
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        step();
        n_total++;
        if (fflags !== 5'b00100)
            $display("FAIL clr_setup: got %b, want 00100", fflags);
        else n_pass++;
        drive(1'b1, 16'h5678, 5'b00010, 5'd2);
        step();
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        n_total++;
        if ({fflags, count} !== {5'b00010, 2'd0})
            $display("FAIL clr_race: got ff=%b cnt=%0d, want ff=00010 cnt=0", fflags, count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.wb_ready = 1'b0;
        drive(1'b1, 16'h0101, 5'b01000, 5'd4);
        step();
        drive(1'b1, 16'h0202, 5'b01000, 5'd5);
        step();
        drive(1'b0, 16'h0, 5'h0, 5'h0);
        n_total++;
        if ({count, fflags} !== {2'd2, 5'b00010})
            $display("FAIL arst_setup: got cnt=%0d ff=%b, want cnt=2 ff=00010", count, fflags);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({count, bus.wb_valid, fflags, bus.res_ready, bus.wb_data} !== {2'd0, 1'b0, 5'd0, 1'b1, 16'h0})
            $display("FAIL arst_now: got cnt=%0d v=%b ff=%b rdy=%b data=%h, want cnt=0 v=0 ff=00000 rdy=1 data=0000",
                     count, bus.wb_valid, fflags, bus.res_ready, bus.wb_data);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        step();
        n_total++;
        if ({count, bus.wb_valid} !== {2'd0, 1'b0})
            $display("FAIL arst_after: got cnt=%0d v=%b, want cnt=0 v=0", count, bus.wb_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_nan();
        test_flag_clr_race();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dlf16_result_wb.md
# dlf16_result_wb

Writeback stage directly downstream of the DLFloat16 sign-manipulation unit (and any other DLFloat16 FPU unit sharing its result format). Accepts registered results plus 5-bit exception flags over a valid/ready handshake, buffers them in a small FIFO, and optionally canonicalizes NaN. It presents results to the register-file writeback port in order and accumulates sticky exception flags (fflags) that software reads and clears.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2.
- TAG_W, 5, destination-register tag width.
- CANON_NAN, 1, 1 = rewrite any NaN result to canonical 16'h7FFF.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- res_valid  in  1  upstream result valid.
- res_ready  out  1  stage can accept a result.
- res_data  in  16  DLFloat16 result (s[15], e[14:9], m[8:0]).
- res_exc  in  5  exception flags {NV,DZ,OF,UF,NX} = [4:0].
- res_tag  in  TAG_W  destination tag.
- wb_valid  out  1  writeback entry valid.
- wb_ready  in  1  register file accepts entry.
- wb_data  out  16  result to write.
- wb_tag  out  TAG_W  destination tag.
- wb_exc  out  5  flags of the current entry.
- flags_clr  in  1  clear sticky flags (one-cycle pulse).
- fflags  out  5  sticky accumulated flags.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push when res_valid && res_ready; pop when wb_valid && wb_ready.
- res_ready = (count != DEPTH); depends only on registered state, not on wb_ready.
- wb_valid = (count != 0); wb_data/wb_tag/wb_exc driven from head entry.
- Storage: circular buffer, wr_ptr/rd_ptr log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- count: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- Simultaneous push and pop when full: push refused (res_ready=0), pop proceeds; count DEPTH→DEPTH-1.
- Simultaneous push and pop when empty: only push occurs (no bypass); count 0→1.
- NaN canonicalization at push: if CANON_NAN and res_data[14:0]==15'h7FFF, stored data = 16'h7FFF (sign dropped); otherwise stored unchanged. res_exc stored unchanged.
- Sticky flags: fflags_next = (flags_clr ? 0 : fflags) | (pop ? wb_exc : 0). Flags are accumulated at pop, not push. Clear and same-cycle pop: popped entry's flags survive.
- Upstream data changes while res_valid && !res_ready are ignored; no entry lost or duplicated.

## Timing
- Reset (async assert, sync-released use on next clk): wr_ptr=rd_ptr=0, count=0, fflags=0, wb_valid=0, res_ready=1; wb_data/wb_tag/wb_exc=0 (storage cleared).
- Latency: result pushed at edge N is on wb_* with wb_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 result/cycle sustained when wb_ready held high.
- fflags updates on the edge where the pop occurs; visible next cycle.
- Reset mid-operation: all buffered entries discarded, fflags cleared immediately (asynchronous).

## Test plan
- Single pass: push 16'h3E00, exc 5'b00001, tag 3, wb_ready=1 -> next cycle wb_valid=1, wb_data=16'h3E00, wb_tag=3; after pop fflags=5'b00001, count=0.
- Backpressure/full: wb_ready=0, push 3 results (DEPTH=2) -> res_ready=0 after 2nd push, count=2, 3rd held by upstream; release wb_ready -> outputs in order, 3rd accepted once count<2, none lost.
- Push+pop when full: count=2, res_valid=1, wb_ready=1 -> pop only, count=1, res_ready=1 next cycle.
- NaN canonicalization: push 16'hFFFF, exc 5'b10000 -> wb_data=16'h7FFF, wb_exc=5'b10000, fflags[4]=1; with CANON_NAN=0 -> wb_data=16'hFFFF.
- Flag clear race: fflags=5'b00100, flags_clr=1 same cycle as pop with exc 5'b00010 -> fflags=5'b00010.
- Async reset mid-stream: assert rst_n=0 with count=2, fflags≠0 between edges -> count=0, wb_valid=0, fflags=0, res_ready=1 immediately.
